// File: rtl/filter_bank_rr.sv
// filter_bank_rr: range-limited filter bank with per-lane survivor FIFOs
// drained by a round-robin arbiter into one valid/ready output stream.
// Optional statistics counters are built when FILTER_BANK_STATS_EN is defined;
// otherwise pass_count and reject_count read 0.
//
// Output handshake: an entry transfers on a clock edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 every out_* signal
// holds its value; out_valid never drops without a transfer.
module filter_bank_rr #(
  parameter int DATA_WIDTH               = 32,
  parameter int ID_WIDTH                 = 16,
  parameter int NUM_FILTER               = 4,
  parameter int LANE_ID_WIDTH            = 2,
  parameter int FILTER_BUFFER_ADDR_WIDTH = 5,
  parameter int BP_MARGIN                = 4,
  parameter logic [DATA_WIDTH-1:0] CUTOFF_2 = 32'h43100000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_FILTER-1:0]            in_valid,
  input  logic [NUM_FILTER*ID_WIDTH-1:0]   in_id,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0] in_r2,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0] in_dx,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0] in_dy,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0] in_dz,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ID_WIDTH-1:0]              out_id,
  output logic [DATA_WIDTH-1:0]            out_r2,
  output logic [DATA_WIDTH-1:0]            out_dx,
  output logic [DATA_WIDTH-1:0]            out_dy,
  output logic [DATA_WIDTH-1:0]            out_dz,
  output logic [LANE_ID_WIDTH-1:0]         out_lane,
  output logic [NUM_FILTER-1:0]            back_pressure,
  output logic [NUM_FILTER-1:0]            overflow,
  output logic [31:0]                      pass_count,
  output logic [31:0]                      reject_count
);

  localparam int AW    = FILTER_BUFFER_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;
  localparam int EW    = ID_WIDTH + 4 * DATA_WIDTH;
  localparam logic [CW:0] BP_LEVEL = (CW+1)'(DEPTH - BP_MARGIN);

  // Sign must be clear and the magnitude strictly below the cutoff; for
  // non-negative IEEE floats the bit pattern orders like an unsigned integer.
  function automatic logic passes(input logic [DATA_WIDTH-1:0] r2);
    return !r2[DATA_WIDTH-1] && (r2[DATA_WIDTH-2:0] < CUTOFF_2[DATA_WIDTH-2:0]);
  endfunction

  function automatic logic [LANE_ID_WIDTH-1:0] lane_at(
    input logic [LANE_ID_WIDTH-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_FILTER) s = s - NUM_FILTER;
    return LANE_ID_WIDTH'(s);
  endfunction

  logic [NUM_FILTER-1:0]    st_valid, st_pass;
  logic [EW-1:0]            st_data [NUM_FILTER];
  logic [EW-1:0]            mem     [NUM_FILTER][DEPTH];
  logic [AW-1:0]            wr_ptr  [NUM_FILTER];
  logic [AW-1:0]            rd_ptr  [NUM_FILTER];
  logic [CW-1:0]            cnt     [NUM_FILTER];
  logic [CW-1:0]            cnt_nxt [NUM_FILTER];
  logic [NUM_FILTER-1:0]    nonempty, full, wr_req, wr_en, rd_en, drop, bp_nxt;
  logic [LANE_ID_WIDTH-1:0] rr_ptr, gnt_lane;
  logic                     gnt_any, load;
  logic [EW-1:0]            head;

  // Compare stage: capture each lane's input and its pass decision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FILTER; i++) begin
      if (!rst) begin
        st_valid[i] <= 1'b0;
        st_pass[i]  <= 1'b0;
        st_data[i]  <= '0;
      end else begin
        st_valid[i] <= in_valid[i];
        st_pass[i]  <= passes(in_r2[i*DATA_WIDTH +: DATA_WIDTH]);
        st_data[i]  <= {in_id[i*ID_WIDTH +: ID_WIDTH],
                        in_r2[i*DATA_WIDTH +: DATA_WIDTH],
                        in_dx[i*DATA_WIDTH +: DATA_WIDTH],
                        in_dy[i*DATA_WIDTH +: DATA_WIDTH],
                        in_dz[i*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  // FIFO occupancy flags.
  always_comb begin
    nonempty = '0;
    full     = '0;
    for (int i = 0; i < NUM_FILTER; i++) begin
      nonempty[i] = (cnt[i] != '0);
      full[i]     = (cnt[i] == CW'(DEPTH));
    end
  end

  // Round-robin grant: first non-empty lane at or after rr_ptr.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_lane = '0;
    for (int k = NUM_FILTER - 1; k >= 0; k--) begin
      if (nonempty[lane_at(rr_ptr, k)]) begin
        gnt_any  = 1'b1;
        gnt_lane = lane_at(rr_ptr, k);
      end
    end
  end

  assign load = (!out_valid || out_ready) && gnt_any;
  assign head = mem[gnt_lane][rd_ptr[gnt_lane]];

  // Per-lane write/read/drop decisions and next occupancy.
  always_comb begin
    wr_req = '0;
    wr_en  = '0;
    rd_en  = '0;
    drop   = '0;
    bp_nxt = '0;
    for (int i = 0; i < NUM_FILTER; i++) begin
      wr_req[i]  = st_valid[i] & st_pass[i];
      rd_en[i]   = load && (gnt_lane == LANE_ID_WIDTH'(i));
      wr_en[i]   = wr_req[i] & (!full[i] | rd_en[i]);
      drop[i]    = wr_req[i] & full[i] & !rd_en[i];
      cnt_nxt[i] = cnt[i] + CW'(wr_en[i]) - CW'(rd_en[i]);
      bp_nxt[i]  = ({1'b0, cnt_nxt[i]} + (CW+1)'(in_valid[i])) >= BP_LEVEL;
    end
  end

  // FIFO storage; contents are don't-care after reset since pointers clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FILTER; i++) begin
      if (wr_en[i]) mem[i][wr_ptr[i]] <= st_data[i];
    end
  end

  // FIFO pointers, counts, sticky overflow and registered back-pressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FILTER; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      overflow      <= '0;
      back_pressure <= '0;
    end else begin
      for (int i = 0; i < NUM_FILTER; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt_nxt[i];
        if (drop[i]) overflow[i] <= 1'b1;
      end
      back_pressure <= bp_nxt;
    end
  end

  // Output register and arbiter pointer; pointer advances only on a grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_r2    <= '0;
      out_dx    <= '0;
      out_dy    <= '0;
      out_dz    <= '0;
      out_lane  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      {out_id, out_r2, out_dx, out_dy, out_dz} <= head;
      out_lane  <= gnt_lane;
      rr_ptr    <= lane_at(gnt_lane, 1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FILTER_BANK_STATS_EN
  logic [31:0] pass_inc, rej_inc;

  // Count passing/rejected pairs held in the compare stage this cycle.
  always_comb begin
    pass_inc = '0;
    rej_inc  = '0;
    for (int i = 0; i < NUM_FILTER; i++) begin
      pass_inc = pass_inc + 32'(st_valid[i] & st_pass[i]);
      rej_inc  = rej_inc  + 32'(st_valid[i] & !st_pass[i]);
    end
  end

  // Free-running statistics, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pass_count   <= '0;
      reject_count <= '0;
    end else begin
      pass_count   <= pass_count + pass_inc;
      reject_count <= reject_count + rej_inc;
    end
  end
`else
  assign pass_count   = '0;
  assign reject_count = '0;
`endif

endmodule

// File: tb/tb_filter_bank_rr.sv
// tb_filter_bank_rr: directed bench for filter_bank_rr with an expected-entry
// queue filled by the stimulus tasks and emptied by an output monitor.
module tb_filter_bank_rr;

  localparam int DW = 32;
  localparam int IW = 16;
  localparam int NF = 4;
  localparam int LW = 2;
  localparam int EW = LW + IW + 4 * DW;

  logic             clk, rst;
  logic [NF-1:0]    in_valid;
  logic [NF*IW-1:0] in_id;
  logic [NF*DW-1:0] in_r2, in_dx, in_dy, in_dz;
  logic             out_valid, out_ready;
  logic [IW-1:0]    out_id;
  logic [DW-1:0]    out_r2, out_dx, out_dy, out_dz;
  logic [LW-1:0]    out_lane;
  logic [NF-1:0]    back_pressure, overflow;
  logic [31:0]      pass_count, reject_count;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  filter_bank_rr #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .NUM_FILTER(NF), .LANE_ID_WIDTH(LW),
    .FILTER_BUFFER_ADDR_WIDTH(5), .BP_MARGIN(4), .CUTOFF_2(32'h43100000)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_id(in_id), .in_r2(in_r2),
    .in_dx(in_dx), .in_dy(in_dy), .in_dz(in_dz),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_r2(out_r2), .out_dx(out_dx), .out_dy(out_dy),
    .out_dz(out_dz), .out_lane(out_lane),
    .back_pressure(back_pressure), .overflow(overflow),
    .pass_count(pass_count), .reject_count(reject_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [EW-1:0] mk(input logic [LW-1:0] lane,
                                       input logic [IW-1:0] id,
                                       input logic [DW-1:0] r2);
    return {lane, id, r2, {16'h1111, id}, {16'h2222, id}, {16'h3333, id}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic set_lane(input int lane, input logic [IW-1:0] id,
                          input logic [DW-1:0] r2, input bit expect_pass);
    in_valid[lane] = 1'b1;
    in_id[lane*IW +: IW] = id;
    in_r2[lane*DW +: DW] = r2;
    in_dx[lane*DW +: DW] = {16'h1111, id};
    in_dy[lane*DW +: DW] = {16'h2222, id};
    in_dz[lane*DW +: DW] = {16'h3333, id};
    if (expect_pass) exp_q.push_back(mk(LW'(lane), id, r2));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    in_valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst      = 1'b0;
    in_valid = '1;
    repeat (cycles) @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = '0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries still expected after %0d cycles", exp_q.size(), n);
      exp_q.delete();
    end
    idle(3);
  endtask

  task automatic check_stats(input string name, input logic [31:0] p, input logic [31:0] r);
`ifdef FILTER_BANK_STATS_EN
    check({name, "_pass"}, 64'(pass_count), 64'(p));
    check({name, "_rej"}, 64'(reject_count), 64'(r));
`else
    check({name, "_pass"}, 64'(pass_count), 64'(0));
    check({name, "_rej"}, 64'(reject_count), 64'(0));
`endif
  endtask

  // Scoreboard monitor: every accepted output must match the queue head.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got lane %0d id %h with no entry expected", out_lane, out_id);
      end else begin
        logic [EW-1:0] e, a;
        e = exp_q.pop_front();
        a = {out_lane, out_id, out_r2, out_dx, out_dy, out_dz};
        if (a !== e) begin
          bad++;
          $display("FAIL out_entry: got %h want %h", a, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; out_ready = 1'b1; in_valid = '0;
    in_id = '0; in_r2 = '0; in_dx = '0; in_dy = '0; in_dz = '0;

    // Reset with all lanes strobing
    do_reset(3);
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data", {out_lane, out_id, out_r2}, 64'(0));
    check("rst_bp", 64'(back_pressure), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check_stats("rst", 32'd0, 32'd0);
    idle(5);
    check("rst_quiet", 64'(out_valid), 64'(0));

    // Cutoff boundary and first-output latency on lane 0
    set_lane(0, 16'h0100, 32'h43100000, 1'b0); step();
    set_lane(0, 16'h0101, 32'h430FFFFF, 1'b1); step();
    set_lane(0, 16'h0102, 32'hC0000000, 1'b0); step();
    check("lat_early", 64'(out_valid), 64'(0));
    set_lane(0, 16'h0103, 32'h00000000, 1'b1); step();
    check("lat_first", {out_valid, out_lane, out_id}, {1'b1, 2'd0, 16'h0101});
    wait_drain(50);
    check_stats("cut", 32'd2, 32'd2);

    // Fairness: all lanes loaded every cycle for 8 cycles
    do_reset(2);
    for (int j = 0; j < 8; j++) begin
      for (int l = 0; l < NF; l++)
        set_lane(l, 16'(16'h1000 + l * 16 + j), 32'h3F800000, 1'b1);
      step();
    end
    wait_drain(200);
    check_stats("fair", 32'd32, 32'd0);

    // Stall: output held while out_ready is low
    out_ready = 1'b0;
    set_lane(1, 16'h2001, 32'h40000000, 1'b1); step();
    set_lane(1, 16'h2002, 32'h40400000, 1'b1); step();
    begin
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin idle(1); n++; end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_hold", {out_lane, out_id, out_r2}, {2'd1, 16'h2001, 32'h40000000});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(50);

    // Back-pressure and overflow on lane 2 with the output stalled
    do_reset(2);
    out_ready = 1'b0;
    for (int k = 0; k < 34; k++) begin
      set_lane(2, 16'(16'h3000 + k), 32'h41000000, k < 33);
      step();
      if (k == 27) check("bp_low", 64'(back_pressure), 64'(0));
      if (k == 28) check("bp_high", 64'(back_pressure), 64'(4'b0100));
      if (k == 33) check("ovf_before", 64'(overflow), 64'(0));
    end
    idle(1);
    check("ovf_set", 64'(overflow), 64'(4'b0100));
    check("bp_full", 64'(back_pressure), 64'(4'b0100));
    check_stats("bp", 32'd34, 32'd0);
    out_ready = 1'b1;
    wait_drain(200);
    check("ovf_sticky", 64'(overflow), 64'(4'b0100));
    check("bp_clear", 64'(back_pressure), 64'(0));

    // Mid-operation reset discards buffered entries
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_lane(3, 16'(16'h4000 + k), 32'h3F000000, 1'b0);
      step();
    end
    idle(3);
    check("mid_busy", 64'(out_valid), 64'(1));
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("mid_valid", 64'(out_valid), 64'(0));
    check("mid_ovf", 64'(overflow), 64'(0));
    check("mid_bp", 64'(back_pressure), 64'(0));
    check_stats("mid", 32'd0, 32'd0);
    out_ready = 1'b1;
    set_lane(1, 16'h5001, 32'h3E800000, 1'b1); step();
    wait_drain(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
